fft_ctrl: RTL and testbench



---
 rtl/fft_pkg.sv | 19 +
 rtl/fft_ctrl_counter.sv | 24 ++
 rtl/fft_ctrl.sv | 131 +++++++++++++
 tb/tb_fft_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT controller types: state encoding and point-count derivation,
// reused by the controller and by FFT-top integration.
package fft_pkg;

    typedef enum logic [1:0] {
        S_CLR   = 2'd0,
        S_LOAD  = 2'd1,
        S_START = 2'd2,
        S_RUN   = 2'd3
    } fft_state_t;

    localparam int unsigned N_2_DEFAULT = 5;
    localparam int unsigned N_DEFAULT   = 1 << N_2_DEFAULT;

    function automatic int unsigned fft_points(input int unsigned n2);
        return 1 << n2;
    endfunction

endpackage

// File: rtl/fft_ctrl_counter.sv
// Up-counter with synchronous clear, count enable and terminal-count compare.
module fft_ctrl_counter #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_tc_val,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = (r_count == i_tc_val);

endmodule

// File: rtl/fft_ctrl.sv
// FFT core sequencer: loads N samples, starts the core, forwards N result
// beats, and abandons the frame with a sticky error if the core stalls.
module fft_ctrl
    import fft_pkg::*;
#(
    parameter int width   = 16,
    parameter int N_2     = int'(N_2_DEFAULT),
    parameter int TIMEOUT = 4 * N_2 * (2 ** (N_2 - 1))
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [width-1:0]   in_data,
    output logic               out_valid,
    output logic [2*width-1:0] out_data,
    output logic               out_last,
    output logic               busy,
    output logic               err,
    output logic [15:0]        frame_count,
    output logic               fft_reset,
    output logic               fft_load,
    output logic               fft_start,
    output logic [width-1:0]   fft_rd,
    input  logic [2*width-1:0] fft_wd,
    input  logic               fft_done
);

    localparam int N  = int'(fft_points(N_2));
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [N_2-1:0] LAST_IDX = N_2'(N - 1);
    localparam logic [TW-1:0]  TO_LIMIT = TW'(TIMEOUT);

    fft_state_t r_state;
    fft_state_t w_next;

    logic w_clr;
    logic w_smp_tc;
    logic w_beat_tc;
    logic w_to_tc;
    logic w_to_en;

    assign w_clr     = reset | (r_state == S_CLR);
    assign fft_reset = w_clr;
    assign busy      = (r_state != S_LOAD);
    assign fft_rd    = in_data;
    assign out_data  = fft_wd;

    fft_ctrl_counter #(.W(N_2)) u_smp_cnt (
        .i_clk    (clk),
        .i_clr    (w_clr),
        .i_en     (fft_load),
        .i_tc_val (LAST_IDX),
        .o_tc     (w_smp_tc)
    );

    fft_ctrl_counter #(.W(N_2)) u_beat_cnt (
        .i_clk    (clk),
        .i_clr    (w_clr),
        .i_en     (out_valid),
        .i_tc_val (LAST_IDX),
        .o_tc     (w_beat_tc)
    );

    fft_ctrl_counter #(.W(TW)) u_to_cnt (
        .i_clk    (clk),
        .i_clr    (w_clr),
        .i_en     (w_to_en),
        .i_tc_val (TO_LIMIT),
        .o_tc     (w_to_tc)
    );

    always_ff @(posedge clk) begin
        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        fft_load  = 1'b0;
        fft_start = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        w_to_en   = 1'b0;
        case (r_state)
            S_CLR: w_next = S_LOAD;
            S_LOAD: begin
                in_ready = 1'b1;
                fft_load = in_valid;
                if (in_valid && w_smp_tc) w_next = S_START;
            end
            S_START: begin
                fft_start = 1'b1;
                w_next    = S_RUN;
            end
            S_RUN: begin
                // Timeout wins over a same-cycle done: the frame is dropped.
                if (w_to_tc) begin
                    w_next = S_CLR;
                end else if (fft_done) begin
                    out_valid = 1'b1;
                    out_last  = w_beat_tc;
                    if (w_beat_tc) w_next = S_CLR;
                end else begin
                    w_to_en = 1'b1;
                end
            end
            default: w_next = S_CLR;
        endcase
        if (reset) begin
            w_next    = S_CLR;
            in_ready  = 1'b0;
            fft_load  = 1'b0;
            fft_start = 1'b0;
            out_valid = 1'b0;
            out_last  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err         <= 1'b0;
            frame_count <= '0;
        end else begin
            if (r_state == S_RUN && w_to_tc) err <= 1'b1;
            if (out_last) frame_count <= frame_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_fft_ctrl.sv
// Randomized self-checking bench for fft_ctrl with a frame-level reference model.
module tb_fft_ctrl;

    localparam int W    = 16;
    localparam int N_2  = 5;
    localparam int N    = 32;
    localparam int TO_A = 4 * N_2 * (2 ** (N_2 - 1));
    localparam int TO_B = 10;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic [W-1:0]   in_data;
    logic [2*W-1:0] fft_wd;
    logic           fft_done;
    bit             sel;

    logic a_in_ready, a_out_valid, a_out_last, a_busy, a_err, a_fft_reset, a_fft_load, a_fft_start;
    logic b_in_ready, b_out_valid, b_out_last, b_busy, b_err, b_fft_reset, b_fft_load, b_fft_start;
    logic [2*W-1:0] a_out_data, b_out_data;
    logic [15:0]    a_frame_count, b_frame_count;
    logic [W-1:0]   a_fft_rd, b_fft_rd;

    logic m_in_ready, m_out_valid, m_out_last, m_busy, m_err, m_fft_reset, m_fft_load, m_fft_start;
    logic [2*W-1:0] m_out_data;
    logic [15:0]    m_frame_count;
    logic [W-1:0]   m_fft_rd;

    int n_checks = 0;
    int n_errors = 0;
    int fc_exp   = 0;
    bit err_exp  = 1'b0;

    always #5 clk = ~clk;

    fft_ctrl #(.width(W), .N_2(N_2)) u_dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .out_valid(a_out_valid), .out_data(a_out_data),
        .out_last(a_out_last), .busy(a_busy), .err(a_err), .frame_count(a_frame_count),
        .fft_reset(a_fft_reset), .fft_load(a_fft_load), .fft_start(a_fft_start),
        .fft_rd(a_fft_rd), .fft_wd(fft_wd), .fft_done(fft_done)
    );

    fft_ctrl #(.width(W), .N_2(N_2), .TIMEOUT(TO_B)) u_dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .out_valid(b_out_valid), .out_data(b_out_data),
        .out_last(b_out_last), .busy(b_busy), .err(b_err), .frame_count(b_frame_count),
        .fft_reset(b_fft_reset), .fft_load(b_fft_load), .fft_start(b_fft_start),
        .fft_rd(b_fft_rd), .fft_wd(fft_wd), .fft_done(fft_done)
    );

    assign m_in_ready    = sel ? b_in_ready    : a_in_ready;
    assign m_out_valid   = sel ? b_out_valid   : a_out_valid;
    assign m_out_last    = sel ? b_out_last    : a_out_last;
    assign m_busy        = sel ? b_busy        : a_busy;
    assign m_err         = sel ? b_err         : a_err;
    assign m_fft_reset   = sel ? b_fft_reset   : a_fft_reset;
    assign m_fft_load    = sel ? b_fft_load    : a_fft_load;
    assign m_fft_start   = sel ? b_fft_start   : a_fft_start;
    assign m_out_data    = sel ? b_out_data    : a_out_data;
    assign m_frame_count = sel ? b_frame_count : a_frame_count;
    assign m_fft_rd      = sel ? b_fft_rd      : a_fft_rd;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic check_excl();
        check("excl", 64'(int'(m_fft_load) + int'(m_fft_start) + int'(m_out_valid) <= 1), 64'(1));
    endtask

    task automatic do_reset();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            reset = 1'b1; in_valid = 1'b1; fft_done = 1'b1; fft_wd = $urandom;
            #1;
            check("rst_in_ready",  64'(m_in_ready),  64'(0));
            check("rst_out_valid", 64'(m_out_valid), 64'(0));
            check("rst_out_last",  64'(m_out_last),  64'(0));
            check("rst_fft_load",  64'(m_fft_load),  64'(0));
            check("rst_fft_start", 64'(m_fft_start), 64'(0));
            check("rst_fft_reset", 64'(m_fft_reset), 64'(1));
        end
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b1; fft_done = 1'b1;
        err_exp = 1'b0; fc_exp = 0;
        #1;
        check("clr_fft_reset", 64'(m_fft_reset),   64'(1));
        check("clr_in_ready",  64'(m_in_ready),    64'(0));
        check("clr_out_valid", 64'(m_out_valid),   64'(0));
        check("clr_busy",      64'(m_busy),        64'(1));
        check("clr_err",       64'(m_err),         64'(0));
        check("clr_fc",        64'(m_frame_count), 64'(0));
    endtask

    // mode 0: back-to-back samples 0..N-1, mode 1: valid toggles 1,0,..., mode 2: random
    task automatic load_frame(input int mode);
        int acc = 0;
        int cyc = 0;
        while (acc < N) begin
            @(negedge clk);
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = (cyc % 2 == 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data  = (mode == 0) ? W'(acc) : W'($urandom);
            fft_done = 1'($urandom_range(0, 1));
            fft_wd   = $urandom;
            #1;
            check("ld_in_ready",  64'(m_in_ready),  64'(1));
            check("ld_fft_load",  64'(m_fft_load),  64'(in_valid));
            check("ld_fft_rd",    64'(m_fft_rd),    64'(in_data));
            check("ld_fft_start", 64'(m_fft_start), 64'(0));
            check("ld_out_valid", 64'(m_out_valid), 64'(0));
            check("ld_busy",      64'(m_busy),      64'(0));
            check("ld_fft_reset", 64'(m_fft_reset), 64'(0));
            check_excl();
            if (in_valid) acc++;
            cyc++;
            if (cyc >= 1000) begin
                check("load_budget", 64'(0), 64'(1));
                return;
            end
        end
        @(negedge clk);
        in_valid = 1'b1; in_data = $urandom; fft_done = 1'($urandom_range(0, 1));
        #1;
        check("st_fft_start", 64'(m_fft_start), 64'(1));
        check("st_in_ready",  64'(m_in_ready),  64'(0));
        check("st_fft_load",  64'(m_fft_load),  64'(0));
        check("st_out_valid", 64'(m_out_valid), 64'(0));
        check("st_busy",      64'(m_busy),      64'(1));
    endtask

    // Reference: done=0 cycles count toward the timeout; once the timeout
    // count equals the limit the frame is dropped; each done=1 cycle is a beat.
    task automatic run_frame(input int delay, input int gap_pct, input bit force_idle, input int stop_beats);
        int  tmo   = sel ? TO_B : TO_A;
        int  to_cnt = 0;
        int  beats  = 0;
        int  cyc    = 0;
        bit  fin    = 1'b0;
        bit  timed  = 1'b0;
        while (!fin) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            in_data  = $urandom;
            fft_wd   = $urandom;
            if (force_idle || cyc < delay) fft_done = 1'b0;
            else if (to_cnt >= tmo - 2)    fft_done = 1'b1;
            else                           fft_done = ($urandom_range(0, 99) >= gap_pct);
            #1;
            check("run_in_ready",  64'(m_in_ready),  64'(0));
            check("run_fft_load",  64'(m_fft_load),  64'(0));
            check("run_fft_start", 64'(m_fft_start), 64'(0));
            check("run_fft_reset", 64'(m_fft_reset), 64'(0));
            check("run_busy",      64'(m_busy),      64'(1));
            check("run_err",       64'(m_err),       64'(err_exp));
            check_excl();
            if (to_cnt == tmo) begin
                check("to_out_valid", 64'(m_out_valid), 64'(0));
                check("to_out_last",  64'(m_out_last),  64'(0));
                timed = 1'b1; err_exp = 1'b1; fin = 1'b1;
            end else if (fft_done) begin
                check("beat_valid", 64'(m_out_valid), 64'(1));
                check("beat_data",  64'(m_out_data),  64'(fft_wd));
                check("beat_last",  64'(m_out_last),  64'(beats == N - 1));
                beats++;
                if (beats == N) begin
                    fc_exp = (fc_exp + 1) % 65536;
                    fin = 1'b1;
                end
            end else begin
                check("gap_valid", 64'(m_out_valid), 64'(0));
                to_cnt++;
            end
            if (beats == stop_beats) fin = 1'b1;
            cyc++;
            if (cyc >= 2000) begin
                check("run_budget", 64'(0), 64'(1));
                fin = 1'b1;
            end
        end
        if (beats == N || timed) begin
            @(negedge clk);
            in_valid = 1'b1; fft_done = 1'b1;
            #1;
            check("post_fft_reset", 64'(m_fft_reset),   64'(1));
            check("post_in_ready",  64'(m_in_ready),    64'(0));
            check("post_out_valid", 64'(m_out_valid),   64'(0));
            check("post_busy",      64'(m_busy),        64'(1));
            check("post_err",       64'(m_err),         64'(err_exp));
            check("post_fc",        64'(m_frame_count), 64'(fc_exp));
        end
    endtask

    task automatic idle_check();
        @(negedge clk);
        in_valid = 1'b0; fft_done = 1'b0;
        #1;
        check("idle_in_ready",  64'(m_in_ready),    64'(1));
        check("idle_busy",      64'(m_busy),        64'(0));
        check("idle_fft_load",  64'(m_fft_load),    64'(0));
        check("idle_fft_reset", 64'(m_fft_reset),   64'(0));
        check("idle_fc",        64'(m_frame_count), 64'(fc_exp));
        check("idle_err",       64'(m_err),         64'(err_exp));
    endtask

    initial begin
        sel = 1'b0; reset = 1'b0; in_valid = 1'b0; in_data = '0; fft_wd = '0; fft_done = 1'b0;

        do_reset();
        load_frame(2);
        run_frame(3, 20, 1'b0, 5);
        do_reset();

        load_frame(0);
        run_frame(80, 0, 1'b0, N);
        check("fc_one", 64'(m_frame_count), 64'(1));
        load_frame(1);
        run_frame(int'($urandom_range(0, 40)), 30, 1'b0, N);
        load_frame(2);
        run_frame(int'($urandom_range(0, 40)), 30, 1'b0, N);
        check("fc_three", 64'(m_frame_count), 64'(3));
        idle_check();

        sel = 1'b1;
        do_reset();
        load_frame(2);
        run_frame(0, 0, 1'b1, N);
        check("to_err_set", 64'(m_err), 64'(1));
        idle_check();
        load_frame(1);
        run_frame(5, 0, 1'b0, N);
        idle_check();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
